// File: rtl/step_clock_gen_pkg.sv
// =============================================================================
// Module : clk_pkg
// Shared mode/state encodings and period helper for step_clock_gen.
// Revision: 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

package clk_pkg;

   typedef enum logic [1:0] {
      MODE_RUN    = 2'b00,
      MODE_STEP   = 2'b01,
      MODE_HOLD   = 2'b10,
      MODE_HOLD_X = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOW       = 2'd1,
      ST_HIGH      = 2'd2,
      ST_STEP_HIGH = 2'd3
   } state_e;

   // Shift amounts of 32 or more give 0, which the clamp turns into P=2.
   function automatic logic [31:0] calc_period(input logic [31:0] hz, input logic [31:0] sel);
      logic [31:0] p;
      p = hz >> sel;
      return (p < 32'd2) ? 32'd2 : p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/step_clock_gen_if.sv
// =============================================================================
// Module : step_clock_gen_if
// Control and status bundle for the step clock generator.
// Revision: 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

interface step_clock_gen_if #(
   parameter int unsigned SEL_W = 4
);
   logic [SEL_W-1:0] sel;
   logic [1:0]       mode;
   logic             step;
   logic             slow_clock;
   logic             rise;
   logic             fall;
   logic [31:0]      count;
   logic             busy;

   modport master (output sel, mode, step,
                   input  slow_clock, rise, fall, count, busy);
   modport slave  (input  sel, mode, step,
                   output slow_clock, rise, fall, count, busy);
endinterface

`default_nettype wire

// File: rtl/step_clock_gen_edge_sync.sv
// =============================================================================
// Module : edge_sync
// Multi-flop synchroniser with registered rising-edge pulse output.
// Revision: 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
)(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_pulse;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev  <= r_sync[SYNC_STAGES-1];
         r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
      end
   end

   assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/step_clock_gen.sv
// =============================================================================
// Module : step_clock_gen
// Slow clock generator with run, single-step and hold modes.
// Revision: 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module step_clock_gen
   import clk_pkg::*;
#(
   parameter int unsigned CLOCK_HZ    = 100_000_000,
   parameter int unsigned SEL_W       = 4,
   parameter int unsigned SYNC_STAGES = 2
)(
   input  logic            quick_clock,
   input  logic            reset,
   step_clock_gen_if.slave bus
);

   localparam logic [1:0] S_IDLE      = ST_IDLE;
   localparam logic [1:0] S_LOW       = ST_LOW;
   localparam logic [1:0] S_HIGH      = ST_HIGH;
   localparam logic [1:0] S_STEP_HIGH = ST_STEP_HIGH;
   localparam logic [31:0] C_HZ       = 32'(CLOCK_HZ);

   logic [1:0]       r_state, w_state_nxt;
   logic [31:0]      r_count, w_count_nxt;
   logic [SEL_W-1:0] r_sel_q;
   logic             w_latch_sel;
   logic             r_slow, r_rise, r_fall;
   logic             w_hi_nxt;
   logic             w_step_edge;
   logic [31:0]      w_period, w_half;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
      .clk   (quick_clock),
      .rst_n (reset),
      .din   (bus.step),
      .pulse (w_step_edge)
   );

   // Period depends only on the latched select so mid-period changes are deferred.
   assign w_period = calc_period(C_HZ, 32'(r_sel_q));
   assign w_half   = w_period >> 1;

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count + 32'd1;
      w_latch_sel = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_count_nxt = '0;
            if (bus.mode == MODE_RUN) begin
               w_state_nxt = S_LOW;
               w_latch_sel = 1'b1;
            end else if (bus.mode == MODE_STEP && w_step_edge) begin
               w_state_nxt = S_STEP_HIGH;
               w_latch_sel = 1'b1;
            end
         end
         S_LOW: begin
            if (r_count == w_half - 32'd1) w_state_nxt = S_HIGH;
         end
         S_HIGH: begin
            if (r_count == w_period - 32'd1) begin
               w_count_nxt = '0;
               if (bus.mode == MODE_RUN) begin
                  w_state_nxt = S_LOW;
                  w_latch_sel = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_STEP_HIGH: begin
            if (r_count == w_half - 32'd1) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
         end
      endcase
   end

   assign w_hi_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_STEP_HIGH);

   always_ff @(posedge quick_clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_sel_q <= '0;
         r_slow  <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_latch_sel) r_sel_q <= bus.sel;
         r_slow  <= w_hi_nxt;
         r_rise  <= w_hi_nxt & ~r_slow;
         r_fall  <= ~w_hi_nxt & r_slow;
      end
   end

   assign bus.slow_clock = r_slow;
   assign bus.rise       = r_rise;
   assign bus.fall       = r_fall;
   assign bus.count      = r_count;
   assign bus.busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire
